// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA data memory arbiter.
// Holds the FSM state encoding and the default memory map.
package mem_port_arbiter_pkg;

  localparam logic [31:0] DATA_BASE_ADDR = 32'h1001_0000;
  localparam int          DATA_DEPTH     = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_addr_decode.sv
// addr_decode: byte address to word index plus range/alignment error.
// Subtraction wraps, so addresses below the base land far out of range.
module addr_decode
  import mem_port_arbiter_pkg::*;
#(
  parameter int          DEPTH     = DATA_DEPTH,
  parameter logic [31:0] BASE_ADDR = DATA_BASE_ADDR,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output logic [AW-1:0] index,
  output logic          err
);

  logic [31:0] word;

  // word offset from the base, then alignment and bound checks
  always_comb begin
    word  = (addr - BASE_ADDR) >> 2;
    index = word[AW-1:0];
    err   = (addr[1:0] != 2'b00) || (word >= 32'(DEPTH));
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data RAM port between CPU and DMA.
// Macro ARB_CPU_PRIORITY_EN: fixed CPU priority instead of round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int          DEPTH     = DATA_DEPTH,
  parameter logic [31:0] BASE_ADDR = DATA_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  input  logic                     dma_req,
  input  logic                     dma_we,
  input  logic [31:0]              dma_addr,
  input  logic [31:0]              dma_wdata,
  output logic                     dma_ack,
  output logic                     dma_err,
  output logic [31:0]              rdata,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  arb_state_e  state_q, state_d;
  logic        gnt_dma_q, gnt_dma_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
`ifndef ARB_CPU_PRIORITY_EN
  logic        last_cpu_q, last_cpu_d;
`endif

  logic          pick_dma;
  logic [AW-1:0] dec_index;
  logic          dec_err;

  addr_decode #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .AW        (AW)
  ) u_decode (
    .addr  (addr_q),
    .index (dec_index),
    .err   (dec_err)
  );

  // choose the winner among the requests seen in IDLE
  always_comb begin
`ifdef ARB_CPU_PRIORITY_EN
    pick_dma = !cpu_req;
`else
    pick_dma = dma_req && (!cpu_req || last_cpu_q);
`endif
  end

  // FSM, request latch and load data capture
  always_comb begin
    state_d   = state_q;
    gnt_dma_d = gnt_dma_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifndef ARB_CPU_PRIORITY_EN
    last_cpu_d = last_cpu_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d   = ST_ACCESS;
          gnt_dma_d = pick_dma;
          we_d      = pick_dma ? dma_we    : cpu_we;
          addr_d    = pick_dma ? dma_addr  : cpu_addr;
          wdata_d   = pick_dma ? dma_wdata : cpu_wdata;
`ifndef ARB_CPU_PRIORITY_EN
          last_cpu_d = !pick_dma;
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        rdata_d = (!we_q && !dec_err) ? mem_rdata : 32'd0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_dma_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
`ifndef ARB_CPU_PRIORITY_EN
      last_cpu_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_dma_q <= gnt_dma_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
`ifndef ARB_CPU_PRIORITY_EN
      last_cpu_q <= last_cpu_d;
`endif
    end
  end

  // strobes in ACCESS, acks in RESP, all decoded from state
  always_comb begin
    mem_re    = (state_q == ST_ACCESS) && !we_q && !dec_err;
    mem_we    = (state_q == ST_ACCESS) && we_q && !dec_err;
    mem_addr  = dec_index;
    mem_wdata = wdata_q;
    cpu_ack   = (state_q == ST_RESP) && !gnt_dma_q;
    dma_ack   = (state_q == ST_RESP) && gnt_dma_q;
    cpu_err   = cpu_ack && dec_err;
    dma_err   = dma_ack && dec_err;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed scenarios plus a randomized run against a transaction model.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          DEP  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, cpu_err, dma_ack, dma_err;
  logic [31:0] rdata;
  logic        mem_re, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] env_mem [DEP];
  logic [31:0] ref_mem [DEP];

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_err   (dma_err),
    .rdata     (rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = env_mem[mem_addr];

  always @(posedge clk)
    if (mem_we) env_mem[mem_addr] <= mem_wdata;

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int s = $urandom_range(0, 5);
    if (s <= 2) return BASE + 4 * $urandom_range(0, DEP - 1);
    if (s == 3) return BASE + 4 * $urandom_range(0, DEP - 1) + $urandom_range(1, 3);
    if (s == 4) return BASE - 4 * $urandom_range(1, 100);
    return BASE + 4 * DEP + 4 * $urandom_range(0, 1000);
  endfunction

  function automatic bit addr_bad(logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEP);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    cpu_req = 1; dma_req = 1;
    cpu_addr = BASE; dma_addr = BASE + 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_ack, cpu_err, dma_ack, dma_err, mem_re, mem_we} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outs: got %b expected 000000",
          {cpu_ack, cpu_err, dma_ack, dma_err, mem_re, mem_we});
      end
      n_cmp++;
      if (rdata !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_rdata: got %h expected 0", rdata);
      end
    end
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_write_read();
    apply_reset();
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 32'h1001_0004; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({mem_re, mem_we, mem_addr} !== {1'b0, 1'b1, 10'd1}) begin
      n_bad++;
      $display("FAIL wr_access: got re=%b we=%b a=%0d expected 0 1 1",
        mem_re, mem_we, mem_addr);
    end
    n_cmp++;
    if (mem_wdata !== 32'hDEAD_BEEF || cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_data: got %h ack=%b expected deadbeef 0",
        mem_wdata, cpu_ack);
    end
    cpu_addr = 32'h1001_0100;
    #1;
    n_cmp++;
    if (mem_addr !== 10'd1) begin
      n_bad++;
      $display("FAIL addr_latched: got %0d expected 1", mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_err, dma_ack, rdata} !== {3'b100, 32'd0}) begin
      n_bad++;
      $display("FAIL wr_ack: got %b%b%b %h expected 100 0",
        cpu_ack, cpu_err, dma_ack, rdata);
    end
    ref_mem[1] = 32'hDEAD_BEEF;
    cpu_req = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h1001_0004;
    @(negedge clk);
    n_cmp++;
    if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 10'd1}) begin
      n_bad++;
      $display("FAIL rd_access: got re=%b we=%b a=%0d expected 1 0 1",
        mem_re, mem_we, mem_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_err} !== 2'b10 || rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rd_ack: got ack=%b err=%b %h expected 1 0 deadbeef",
        cpu_ack, cpu_err, rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_access();
    dma_req = 1; dma_we = 1;
    dma_addr = BASE + 20; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre: got we=%b expected 1", mem_we);
    end
    reset = 1;
    #1;
    n_cmp++;
    if ({mem_re, mem_we} !== 2'b00 || rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_strobe: got %b%b %h expected 00 0",
        mem_re, mem_we, rdata);
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cpu_ack, dma_ack} !== 2'b00) begin
        n_bad++;
        $display("FAIL rst_noack: got %b%b expected 00", cpu_ack, dma_ack);
      end
    end
    n_cmp++;
    if (env_mem[5] !== ref_mem[5]) begin
      n_bad++;
      $display("FAIL rst_nowrite: got %h expected %h", env_mem[5], ref_mem[5]);
    end
    reset = 0;
    cpu_req = 1; cpu_addr = BASE;
    @(negedge clk);
    n_cmp++;
    if (mem_re !== 1'b1 || mem_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL rst_idle: got re=%b a=%0d expected 1 0", mem_re, mem_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1 || rdata !== ref_mem[0]) begin
      n_bad++;
      $display("FAIL rst_next: got ack=%b %h expected 1 %h",
        cpu_ack, rdata, ref_mem[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] ta [4];
    bit          tdma [4];
    bit          terr [4];
    int          tidx [4];
    logic [31:0] er;
    ta   = '{32'h1001_0002, 32'h1000_FFFC, 32'h1001_0FFC, 32'h1001_1000};
    tdma = '{1'b0, 1'b1, 1'b1, 1'b1};
    terr = '{1'b1, 1'b1, 1'b0, 1'b1};
    tidx = '{0, 0, 1023, 0};
    for (int i = 0; i < 4; i++) begin
      if (tdma[i]) begin dma_req = 1; dma_we = 0; dma_addr = ta[i]; end
      else begin cpu_req = 1; cpu_we = 0; cpu_addr = ta[i]; end
      @(negedge clk);
      n_cmp++;
      if (terr[i] && {mem_re, mem_we} !== 2'b00) begin
        n_bad++;
        $display("FAIL err_strobe[%0d]: got %b%b expected 00", i, mem_re, mem_we);
      end else if (!terr[i] && (mem_re !== 1'b1 || mem_addr !== 10'(tidx[i]))) begin
        n_bad++;
        $display("FAIL ok_strobe[%0d]: got re=%b a=%0d expected 1 %0d",
          i, mem_re, mem_addr, tidx[i]);
      end
      idle_inputs();
      @(negedge clk);
      er = terr[i] ? 32'd0 : ref_mem[tidx[i]];
      n_cmp++;
      if (tdma[i] && ({cpu_ack, dma_ack, dma_err} !== {2'b01, terr[i]} || rdata !== er)) begin
        n_bad++;
        $display("FAIL dma_err[%0d]: got %b%b%b %h expected 01%b %h",
          i, cpu_ack, dma_ack, dma_err, rdata, terr[i], er);
      end else if (!tdma[i] && ({cpu_ack, dma_ack, cpu_err} !== {2'b10, terr[i]} || rdata !== er)) begin
        n_bad++;
        $display("FAIL cpu_err[%0d]: got %b%b%b %h expected 10%b %h",
          i, cpu_ack, dma_ack, cpu_err, rdata, terr[i], er);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_tie();
    int n = 0;
    bit exp_dma;
    apply_reset();
    cpu_req = 1; cpu_addr = BASE + 8;
    dma_req = 1; dma_addr = BASE + 12;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
`ifdef ARB_CPU_PRIORITY_EN
        exp_dma = 1'b0;
`else
        exp_dma = (n % 2) == 1;
`endif
        n_cmp++;
        if ({cpu_ack, dma_ack} !== {!exp_dma, exp_dma}) begin
          n_bad++;
          $display("FAIL tie_order[%0d]: got %b%b expected %b%b",
            n, cpu_ack, dma_ack, !exp_dma, exp_dma);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 4) begin
      n_bad++;
      $display("FAIL tie_rate: got %0d acks expected 4", n);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_drop_before_grant();
    int seen = 0;
    apply_reset();
    cpu_req = 1; cpu_addr = BASE + 16;
    @(negedge clk);
    cpu_req = 0;
    dma_req = 1; dma_addr = BASE + 24;
    @(negedge clk);
    n_cmp++;
    if (cpu_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_cpu_ack: got %b expected 1", cpu_ack);
    end
    dma_req = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dma_ack || mem_re || mem_we) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL drop_lost: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_random();
    int          next_free = 0;
    int          g = -100;
    bit          last_dma = 1'b1;
    bit          w_dma, w_err;
    logic        w_we;
    logic [31:0] w_wd;
    int          w_idx;
    bit          c_p = 0, d_p = 0;
    logic        c_w, d_w;
    logic [31:0] c_a, c_d, d_a, d_d, er;
    apply_reset();
    for (int k = 0; k < 900; k++) begin
      if (k - 1 == g) begin
        n_cmp++;
        if ({mem_re, mem_we} !== {!w_err && !w_we, !w_err && w_we} ||
            {cpu_ack, dma_ack} !== 2'b00) begin
          n_bad++;
          $display("FAIL rnd_access@%0d: got %b%b%b%b expected %b%b00", k,
            mem_re, mem_we, cpu_ack, dma_ack, !w_err && !w_we, !w_err && w_we);
        end
        if (!w_err) begin
          n_cmp++;
          if (mem_addr !== 10'(w_idx) || (w_we && mem_wdata !== w_wd)) begin
            n_bad++;
            $display("FAIL rnd_addr@%0d: got %0d %h expected %0d %h",
              k, mem_addr, mem_wdata, w_idx, w_wd);
          end
        end
      end else if (k - 1 == g + 1) begin
        er = (!w_we && !w_err) ? ref_mem[w_idx] : 32'd0;
        n_cmp++;
        if ({cpu_ack, dma_ack} !== {!w_dma, w_dma} ||
            (w_dma ? dma_err : cpu_err) !== w_err || rdata !== er ||
            {mem_re, mem_we} !== 2'b00) begin
          n_bad++;
          $display("FAIL rnd_resp@%0d: got ack=%b%b ce=%b de=%b %h expected %b%b err=%b %h",
            k, cpu_ack, dma_ack, cpu_err, dma_err, rdata, !w_dma, w_dma, w_err, er);
        end
        if (w_we && !w_err) ref_mem[w_idx] = w_wd;
        if (w_dma) d_p = 0; else c_p = 0;
      end else begin
        n_cmp++;
        if ({cpu_ack, dma_ack, mem_re, mem_we} !== 4'b0) begin
          n_bad++;
          $display("FAIL rnd_quiet@%0d: got %b expected 0000", k,
            {cpu_ack, dma_ack, mem_re, mem_we});
        end
      end
      if (!c_p && $urandom_range(0, 2) == 0) begin
        c_p = 1; c_w = 1'($urandom); c_a = rand_addr(); c_d = $urandom;
      end
      if (!d_p && $urandom_range(0, 2) == 0) begin
        d_p = 1; d_w = 1'($urandom); d_a = rand_addr(); d_d = $urandom;
      end
      cpu_req = c_p; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
      dma_req = d_p; dma_we = d_w; dma_addr = d_a; dma_wdata = d_d;
      if (k == g + 1) begin
        if (w_dma) begin
          dma_req = 1'($urandom); dma_we = 1'($urandom);
          dma_addr = $urandom; dma_wdata = $urandom;
        end else begin
          cpu_req = 1'($urandom); cpu_we = 1'($urandom);
          cpu_addr = $urandom; cpu_wdata = $urandom;
        end
      end
      if (k >= next_free && (c_p || d_p)) begin
`ifdef ARB_CPU_PRIORITY_EN
        w_dma = !c_p;
`else
        w_dma = d_p && (!c_p || !last_dma);
`endif
        last_dma = w_dma;
        w_we  = w_dma ? d_w : c_w;
        w_wd  = w_dma ? d_d : c_d;
        w_err = addr_bad(w_dma ? d_a : c_a);
        w_idx = int'(((w_dma ? d_a : c_a) - BASE) / 4) % DEP;
        g = k;
        next_free = k + 3;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    logic [31:0] v;
    reset = 1;
    idle_inputs();
    for (int i = 0; i < DEP; i++) begin
      v = $urandom;
      env_mem[i] <= v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_read();
    test_reset_in_access();
    test_errors();
    test_tie();
    test_drop_before_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024: data memory depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h1001_0000: byte address of memory word 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  CPU access request; write when high, read when low.
REQ-006 cpu_addr, cpu_wdata  input  32 each  CPU byte address; CPU store data.
REQ-007 cpu_ack, cpu_err  output  1 each  CPU completion pulse; CPU error flag, valid only with cpu_ack.
REQ-008 dma_req, dma_we  input  1 each  port/DMA access request; write when high, read when low.
REQ-009 dma_addr, dma_wdata  input  32 each  port/DMA byte address; port/DMA store data.
REQ-010 dma_ack, dma_err  output  1 each  port/DMA completion pulse; port/DMA error flag, valid only with dma_ack.
REQ-011 rdata  output  32  load data, valid only in the ack cycle.
REQ-012 mem_re, mem_we  output  1 each  memory read strobe; memory write strobe.
REQ-013 mem_addr  output  clog2(DEPTH)  memory word index.
REQ-014 mem_wdata  output 32 / mem_rdata  input 32  memory write data; memory read data.

Function
REQ-015 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high, ACCESS->RESP always, RESP->IDLE always.
REQ-016 Grant is decided in IDLE; winner's we/addr/wdata are latched on the IDLE->ACCESS edge; later changes to those inputs are ignored.
REQ-017 Default arbitration is round-robin: on simultaneous requests the requester not granted last wins; the last-grant pointer resets to DMA, so the CPU wins the first tie.
REQ-018 Index = (addr - BASE_ADDR) >> 2, 32-bit wrap-around subtraction.
REQ-019 Error when addr[1:0] != 0 or index >= DEPTH (including underflow below BASE_ADDR).
REQ-020 In ACCESS without error: mem_re = !we, mem_we = we, mem_addr = index, mem_wdata = latched wdata, for exactly one cycle.
REQ-021 In ACCESS with error: both strobes are low and memory is untouched.
REQ-022 rdata is registered from mem_rdata at the end of ACCESS; it is zero for writes and for errors.
REQ-023 In RESP only the granted ack pulses for one cycle, with its err; latency from req sampled in IDLE to ack is 2 cycles; throughput is one access per 3 cycles.
REQ-024 Requesters hold req until ack and may keep req high after ack; a request still high in IDLE starts a new transaction.
REQ-025 A request dropped before grant is lost silently; a request dropped after grant still completes and acks.
REQ-026 The losing requester waits; with both requesters held high, grants alternate strictly.

Reset
REQ-027 Reset forces IDLE, clears the pointer, latches and rdata to 0, and drives all acks, errs and strobes to 0 immediately.
REQ-028 A reset during ACCESS or RESP aborts the transaction with no ack.

Configuration
REQ-029 Macro ARB_CPU_PRIORITY_EN: when defined, arbitration is fixed priority with the CPU always winning a tie and the pointer removed.
REQ-030 When ARB_CPU_PRIORITY_EN is undefined, arbitration is round-robin per REQ-017.

Structure
REQ-031 Shared package holds the FSM state enum, DATA_BASE_ADDR = 32'h1001_0000 and DATA_DEPTH = 1024.
REQ-032 Sub-module addr_decode (combinational): byte address -> word index plus error flag; the FSM and arbitration stay in mem_port_arbiter.

Verification
REQ-033 CPU write 0x10010004 data 0xDEADBEEF, then CPU read 0x10010004 -> ACCESS strobes with mem_addr=1, cpu_ack 2 cycles after req, rdata=0xDEADBEEF.
REQ-034 CPU and DMA requests in the same cycle, both held -> grant order CPU, DMA, CPU, DMA; with ARB_CPU_PRIORITY_EN defined -> CPU, CPU, CPU.
REQ-035 CPU read 0x10010002, and DMA read 0x1000FFFC -> each ack arrives with err=1, no strobes, rdata=0.
REQ-036 DMA read of last word 0x10010FFC -> mem_addr=1023, err=0; DMA read of 0x10011000 -> err=1.
REQ-037 Reset asserted in ACCESS -> strobes drop immediately, no ack is produced, FSM is in IDLE on the first edge after reset release.
REQ-038 cpu_addr changed during ACCESS -> mem_addr keeps the latched index.
